// File: rtl/fdc765_lite.sv
// Minimal uPD765 floppy controller on Z80 I/O: MSR/data ports, command/result sequencer, RQM pacing.
// Define FDC765_LITE_MOTOR_PORT_EN to add the motor latch port (0x1xxx); result bytes latch on the read strobe edge.
module fdc765_lite #(
  parameter int NDRIVES   = 2,
  parameter int RQM_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  dout,
  output logic        oe,
  output logic        motor
);

  typedef enum logic [1:0] {IDLE, CMD, RESULT} state_t;
  state_t state_q, state_d;

  logic       rd_act, wr_act, rd_q, wr_q, rd_start, wr_start;
  logic       msr_sel, data_sel, mot_sel;
  logic       rqm, dio, cb, rdy;
  logic [7:0] msr, dout_q, cnt_q;
  logic [4:0] op_q, op;
  logic [3:0] len_q, idx_q;
  logic [2:0] prm_idx, rcnt_q, ridx_q, rcnt_d;
  logic [7:0] prm_q [8];
  logic [7:0] b     [8];
  logic [7:0] res_q [7];
  logic [7:0] res_d [7];
  logic [7:0] pcn_q [4];
  logic [3:0] pending_q, pend_set, pend_clr;
  logic       data_wr, data_rd, last, exec;
  logic [1:0] us, k_sel;
  logic       us_ok, found, t0, pcn_we;
  logic [7:0] pcn_us, pcn_wv, st3;
  logic       unused_ok;

  function automatic logic [3:0] cmd_len(input logic [4:0] o);
    case (o)
      5'h03, 5'h0F:        cmd_len = 4'd3;
      5'h04, 5'h07:        cmd_len = 4'd2;
      5'h05, 5'h06, 5'h0C: cmd_len = 4'd9;
      default:             cmd_len = 4'd1;
    endcase
  endfunction

  assign msr_sel  = (a[15:12] == 4'h2) && !a[1];
  assign data_sel = (a[15:12] == 4'h3) && !a[1];
  assign mot_sel  = (a[15:12] == 4'h1) && !a[1];
  assign rd_act   = !iorq_n && !rd_n;
  assign wr_act   = !iorq_n && !wr_n;
  assign rd_start = rd_act && !rd_q;
  assign wr_start = wr_act && !wr_q;

  assign rqm  = (cnt_q == 8'd0);
  assign dio  = (state_q == RESULT);
  assign cb   = (state_q != IDLE);
  assign msr  = {rqm, dio, 1'b0, cb, 4'b0000};
  assign oe   = rd_act && (msr_sel || data_sel);
  assign dout = (rd_act && msr_sel) ? msr : dout_q;

`ifdef FDC765_LITE_MOTOR_PORT_EN
  logic motor_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) motor_q <= 1'b0;
    else if (wr_start && mot_sel) motor_q <= din[3];
  end
  assign motor = motor_q;
  assign rdy   = motor_q;
  assign unused_ok = ^{a[11:2], a[0], b[0][7:2], b[5], b[6], b[7]};
`else
  assign motor = 1'b0;
  assign rdy   = 1'b0;
  assign unused_ok = ^{a[11:2], a[0], mot_sel, b[0][7:2], b[5], b[6], b[7]};
`endif

  assign data_wr = wr_start && data_sel && rqm && (state_q != RESULT);
  assign data_rd = rd_start && data_sel && rqm && (state_q == RESULT);
  assign prm_idx = 3'(idx_q - 4'd1);
  assign op      = (state_q == IDLE) ? din[4:0] : op_q;
  assign last    = (state_q == IDLE) ? (cmd_len(din[4:0]) == 4'd1) : ((idx_q + 4'd1) == len_q);
  assign exec    = data_wr && last;

  // The byte being written this cycle is folded in so execution sees the full command.
  always_comb begin
    for (int i = 0; i < 8; i++)
      b[i] = (state_q == CMD && prm_idx == 3'(i)) ? din : prm_q[i];
  end

  assign us     = b[0][1:0];
  assign us_ok  = int'(us) < NDRIVES;
  assign pcn_us = us_ok ? pcn_q[us] : 8'h00;
  assign t0     = (pcn_us == 8'h00);
  assign st3    = {2'b00, rdy, t0, 2'b00, us};

  always_comb begin
    found = 1'b0;
    k_sel = 2'd0;
    for (int k = 3; k >= 0; k--)
      if (pending_q[k]) begin
        found = 1'b1;
        k_sel = 2'(k);
      end
  end

  always_comb begin
    for (int i = 0; i < 7; i++) res_d[i] = 8'h00;
    rcnt_d   = 3'd0;
    pcn_we   = 1'b0;
    pcn_wv   = 8'h00;
    pend_set = 4'b0000;
    pend_clr = 4'b0000;
    case (op)
      5'h03: rcnt_d = 3'd0;
      5'h04: begin
        rcnt_d   = 3'd1;
        res_d[0] = st3;
      end
      5'h07, 5'h0F: begin
        pcn_we       = us_ok;
        pcn_wv       = (op == 5'h0F) ? b[1] : 8'h00;
        pend_set[us] = us_ok;
      end
      5'h08: begin
        if (found) begin
          rcnt_d          = 3'd2;
          res_d[0]        = 8'h20 | {6'b0, k_sel};
          res_d[1]        = pcn_q[k_sel];
          pend_clr[k_sel] = 1'b1;
        end else begin
          rcnt_d   = 3'd1;
          res_d[0] = 8'h80;
        end
      end
      5'h05, 5'h06, 5'h0C: begin
        rcnt_d   = 3'd7;
        res_d[0] = 8'h48 | {6'b0, us};
        res_d[3] = b[1];
        res_d[4] = b[2];
        res_d[5] = b[3];
        res_d[6] = b[4];
      end
      default: begin
        rcnt_d   = 3'd1;
        res_d[0] = 8'h80;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, CMD: begin
        if (exec)         state_d = (rcnt_d != 3'd0) ? RESULT : IDLE;
        else if (data_wr) state_d = CMD;
      end
      RESULT: if (data_rd && ridx_q == rcnt_q - 3'd1) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Strobe history starts "active" so a strobe held through reset is not taken as new.
      rd_q      <= 1'b1;
      wr_q      <= 1'b1;
      cnt_q     <= 8'd0;
      dout_q    <= 8'hFF;
      op_q      <= 5'd0;
      len_q     <= 4'd0;
      idx_q     <= 4'd0;
      rcnt_q    <= 3'd0;
      ridx_q    <= 3'd0;
      pending_q <= 4'b0000;
      for (int i = 0; i < 8; i++) prm_q[i] <= 8'h00;
      for (int i = 0; i < 7; i++) res_q[i] <= 8'h00;
      for (int i = 0; i < 4; i++) pcn_q[i] <= 8'h00;
    end else begin
      rd_q <= rd_act;
      wr_q <= wr_act;

      if (data_wr || data_rd)  cnt_q <= 8'(RQM_DELAY);
      else if (cnt_q != 8'd0)  cnt_q <= cnt_q - 8'd1;

      if (data_wr) begin
        if (state_q == IDLE) begin
          op_q  <= din[4:0];
          len_q <= cmd_len(din[4:0]);
          idx_q <= 4'd1;
        end else begin
          prm_q[prm_idx] <= din;
          idx_q          <= idx_q + 4'd1;
        end
      end

      if (exec) begin
        for (int i = 0; i < 7; i++) res_q[i] <= res_d[i];
        rcnt_q    <= rcnt_d;
        ridx_q    <= 3'd0;
        pending_q <= (pending_q | pend_set) & ~pend_clr;
        if (pcn_we) pcn_q[us] <= pcn_wv;
      end

      if (data_rd) begin
        dout_q <= res_q[ridx_q];
        ridx_q <= ridx_q + 3'd1;
      end else if (rd_start && data_sel) begin
        dout_q <= 8'hFF;
      end
    end
  end

endmodule

// File: tb/tb_fdc765_lite.sv
// Directed bench for fdc765_lite: command/result sequences, RQM pacing, reset and motor port.
module tb_fdc765_lite;
  localparam int D = 4;
  localparam logic [15:0] MSR_P  = 16'h2FFD;
  localparam logic [15:0] DATA_P = 16'h3FFD;
  localparam logic [15:0] MOT_P  = 16'h1FFD;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a;
  logic        iorq_n, rd_n, wr_n;
  logic [7:0]  din, dout;
  logic        oe, motor;
  logic [7:0]  v;
  int          n_vec = 0;
  int          n_err = 0;

  fdc765_lite #(.NDRIVES(2), .RQM_DELAY(D)) dut (
    .clk(clk), .rst(rst), .a(a), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .din(din), .dout(dout), .oe(oe), .motor(motor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic io_wr(input logic [15:0] adr, input logic [7:0] d);
    a = adr; din = d; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic io_rd(output logic [7:0] d);
    a = DATA_P; iorq_n = 1'b0; rd_n = 1'b0;
    @(posedge clk); #1;
    d = dout;
    iorq_n = 1'b1; rd_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic msr_chk(input string tag, input logic [7:0] exp);
    a = MSR_P; iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk(tag, dout, exp);
    iorq_n = 1'b1; rd_n = 1'b1; #1;
  endtask

  task automatic settle();
    repeat (D) @(posedge clk);
    #1;
  endtask

  task automatic wr_seq(input logic [7:0] d);
    io_wr(DATA_P, d);
    settle();
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    io_rd(v);
    chk(tag, v, exp);
    settle();
  endtask

  initial begin
    logic [7:0] rd_exp [7];
    logic [7:0] cmd    [9];
    rd_exp = '{8'h48, 8'h00, 8'h00, 8'h05, 8'h00, 8'h03, 8'h02};
    cmd    = '{8'h46, 8'h00, 8'h05, 8'h00, 8'h03, 8'h02, 8'h09, 8'h2A, 8'hFF};
    rst = 1'b1; a = 16'h0000; din = 8'h00;
    iorq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", dout, 8'hFF);
    chk("rst_motor", {7'b0, motor}, 8'h00);
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset status read with output enable
    a = MSR_P; iorq_n = 1'b0; rd_n = 1'b0; #1;
    chk("rst_msr", dout, 8'h80);
    chk("rst_oe", {7'b0, oe}, 8'h01);
    iorq_n = 1'b1; rd_n = 1'b1; #1;
    chk("oe_idle", {7'b0, oe}, 8'h00);

    // Seek drive 1 to track 0x28, then sense interrupt
    wr_seq(8'h0F);
    msr_chk("seek_cmd_msr", 8'h90);
    wr_seq(8'h01);
    wr_seq(8'h28);
    msr_chk("seek_done_msr", 8'h80);
    wr_seq(8'h08);
    msr_chk("sis_res_msr", 8'hD0);
    rd_chk("sis_st0", 8'h21);
    rd_chk("sis_pcn", 8'h28);
    msr_chk("sis_end_msr", 8'h80);

    // RQM low for exactly D clocks after an accepted byte
    a = DATA_P; din = 8'h03; iorq_n = 1'b0; wr_n = 1'b0;
    @(posedge clk); #1;
    iorq_n = 1'b1; wr_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      msr_chk("rqm_low", 8'h10);
      @(posedge clk); #1;
    end
    msr_chk("rqm_high", 8'h90);
    wr_seq(8'h00);
    wr_seq(8'h00);
    msr_chk("specify_end", 8'h80);

    // Write inside the RQM-low window is dropped
    io_wr(DATA_P, 8'h07);
    io_wr(DATA_P, 8'h01);
    settle();
    msr_chk("ignored_wr_msr", 8'h90);
    wr_seq(8'h00);
    msr_chk("recal_end", 8'h80);
    wr_seq(8'h08);
    rd_chk("recal_st0", 8'h20);
    rd_chk("recal_pcn", 8'h00);

    // Read Data: 9 bytes in, 7 results out
    for (int i = 0; i < 9; i++) wr_seq(cmd[i]);
    msr_chk("rdata_msr", 8'hD0);
    for (int i = 0; i < 7; i++) rd_chk($sformatf("rdata_res%0d", i), rd_exp[i]);
    msr_chk("rdata_end", 8'h80);

    // Invalid / empty cases
    wr_seq(8'h08);
    rd_chk("sis_empty", 8'h80);
    wr_seq(8'h1F);
    msr_chk("inv_msr", 8'hD0);
    rd_chk("inv_res", 8'h80);
    rd_chk("extra_rd", 8'hFF);
    msr_chk("extra_rd_msr", 8'h80);

    // Out-of-range drive: no PCN write, no pending
    wr_seq(8'h0F); wr_seq(8'h03); wr_seq(8'h55);
    wr_seq(8'h08);
    rd_chk("oor_sis", 8'h80);
    wr_seq(8'h04); wr_seq(8'h03);
    rd_chk("oor_st3", 8'h13);
    wr_seq(8'h04); wr_seq(8'h01);
    rd_chk("d1_st3", 8'h01);

    // Motor latch port
    io_wr(MOT_P, 8'h08);
    wr_seq(8'h04); wr_seq(8'h00);
`ifdef FDC765_LITE_MOTOR_PORT_EN
    rd_chk("motor_st3", 8'h30);
    chk("motor_pin", {7'b0, motor}, 8'h01);
`else
    rd_chk("motor_st3", 8'h10);
    chk("motor_pin", {7'b0, motor}, 8'h00);
`endif

    // Reset in the middle of a seek and of a result phase
    wr_seq(8'h0F);
    io_wr(DATA_P, 8'h00);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    msr_chk("midrst_msr", 8'h80);
    chk("midrst_motor", {7'b0, motor}, 8'h00);
    wr_seq(8'h08);
    rd_chk("midrst_sis", 8'h80);
    wr_seq(8'h04); wr_seq(8'h01);
    rd_chk("midrst_pcn1", 8'h11);
    wr_seq(8'h1F);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk("midrst_res_rd", 8'hFF);
    msr_chk("midrst_res_msr", 8'h80);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fdc765_lite.md
FDC765_LITE -- requirements
Module: fdc765_lite

Interface
REQ-001 SHALL have parameter NDRIVES, default 2, number of drive units, range 1..4.
REQ-002 SHALL have parameter RQM_DELAY, default 4, clocks RQM stays low after each data-register byte, range 1..255.
REQ-003 SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port a  input  16  Z80 address bus.
REQ-006 SHALL have ports iorq_n, rd_n, wr_n  input  1 each  active-low Z80 strobes.
REQ-007 SHALL have port din  input  8  CPU write data.
REQ-008 SHALL have port dout  output  8  read data.
REQ-009 SHALL have port oe  output  1  high while this block drives dout.
REQ-010 SHALL have port motor  output  1  floppy motor latch.

Function
REQ-011 SHALL decode MSR port as a[15:12]=0010, a[1]=0, and data port as a[15:12]=0011, a[1]=0.
REQ-012 SHALL act on a data-port access once, on the first clk where the strobe pair (iorq_n & rd_n, or iorq_n & wr_n) is low after being high the previous clk.
REQ-013 SHALL drive oe combinationally high only while iorq_n=0, rd_n=0 and MSR or data port decoded.
REQ-014 SHALL return MSR = {RQM, DIO, EXM=0, CB, drive-busy[3:0]=0}; MSR reads have no side effect.
REQ-015 SHALL implement states IDLE, CMD, RESULT, plus a RQM_DELAY hold counter: RQM=0 while counter nonzero, else 1.
REQ-016 SHALL in IDLE: DIO=0, CB=0; data write latches opcode = din[4:0], captures byte count, enters CMD, or directly RESULT/IDLE for 1-byte commands.
REQ-017 SHALL in CMD: DIO=0, CB=1; each data write stores a parameter byte; after the last byte execute and enter RESULT, or IDLE if no result.
REQ-018 SHALL in RESULT: DIO=1, CB=1; each data read returns the next result byte; after the last, enter IDLE.
REQ-019 SHALL restart the RQM_DELAY counter on every accepted data-port byte.
REQ-020 SHALL ignore data writes in RESULT and while RQM=0; data reads outside RESULT or while RQM=0 return 0xFF with no state change.
REQ-021 SHALL support Specify 0x03: 3 bytes, no result.
REQ-022 SHALL support Sense Drive Status 0x04: 2 bytes, result ST3 = {2'b00, RDY, T0, 2'b00, US}, T0 = (PCN[US]==0).
REQ-023 SHALL support Recalibrate 0x07: 2 bytes, PCN[US]=0, set pending[US], no result.
REQ-024 SHALL support Seek 0x0F: 3 bytes, PCN[US]=byte3, set pending[US], no result.
REQ-025 SHALL support Sense Interrupt 0x08: 1 byte; lowest pending drive k gives results ST0=0x20|k then PCN[k], clearing pending[k]; if none pending, single result 0x80.
REQ-026 SHALL support Read Data 0x06, Write Data 0x05, Read Deleted 0x0C: 9 bytes, 7 results ST0=0x48|US, ST1=0x00, ST2=0x00, then C, H, R, N echoed from bytes 3..6.
REQ-027 SHALL treat any other opcode as invalid: single result 0x80.
REQ-028 SHALL use US = byte2[1:0]; for US>=NDRIVES, PCN writes are dropped, PCN reads are 0, pending is not set.

Reset
REQ-029 SHALL on rst: state IDLE, counter 0 (MSR=0x80), all PCN=0, all pending=0, motor=0, oe follows REQ-013, dout=0xFF.
REQ-030 SHALL abandon any command or result sequence when rst asserts mid-operation, with no partial effect after release.

Configuration
REQ-031 SHALL honour macro FDC765_LITE_MOTOR_PORT_EN: when defined, a write with a[15:12]=0001 and a[1]=0 latches motor=din[3] and RDY=motor; when undefined, motor is tied 0, RDY=0, and that port is ignored.

Verification
REQ-032 SHALL cover reset: after rst, MSR read gives 0x80, oe=1 during the read.
REQ-033 SHALL cover Seek: write 0x0F,0x01,0x28, wait, write 0x08 -> reads 0x21 then 0x28, MSR back to 0x80.
REQ-034 SHALL cover RQM timing: after each byte, MSR bit7=0 for exactly RQM_DELAY clocks; a write during that window is ignored.
REQ-035 SHALL cover Read Data: write 0x46,0x00,0x05,0x00,0x03,0x02,0x09,0x2A,0xFF -> results 0x48,0x00,0x00,0x05,0x00,0x03,0x02, MSR 0xD0 during the result phase.
REQ-036 SHALL cover invalid/empty: write 0x08 with none pending -> 0x80; write 0x1F -> 0x80; an extra data read -> 0xFF.
REQ-037 SHALL cover macro: with EN, write 0x08 to 0x1FFD then Sense Drive Status drive 0 -> ST3=0x30; without EN -> 0x10.
